// File: rtl/fir_mac_sequencer.sv
// 31-tap symmetric low-pass FIR built around one shared multiply-accumulate unit.
// Each accepted sample starts a 16-step pair walk, then one saturated, scaled output.
module fir_mac_sequencer #(
  parameter int DATA_W = 10,
  parameter int ACC_W  = 22,
  parameter int SHIFT  = 10
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              sample_valid_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic              busy_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] filtered_o,
  output logic              dropped_o
);

  localparam int TAPS   = 31;
  localparam int COEF_W = 7;
  localparam int PTR_W  = 5;
  localparam int PAIR_W = DATA_W + 1;
  localparam int PROD_W = PAIR_W + COEF_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(TAPS - 1);
  localparam logic [3:0]       K_CENTRE = 4'd15;
  localparam logic [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << DATA_W) - 1);

  function automatic logic [COEF_W-1:0] coef(input logic [3:0] k);
    logic [COEF_W-1:0] c;
    case (k)
      4'd0:    c = 7'd3;
      4'd1:    c = 7'd4;
      4'd2:    c = 7'd6;
      4'd3:    c = 7'd8;
      4'd4:    c = 7'd12;
      4'd5:    c = 7'd17;
      4'd6:    c = 7'd23;
      4'd7:    c = 7'd29;
      4'd8:    c = 7'd36;
      4'd9:    c = 7'd43;
      4'd10:   c = 7'd50;
      4'd11:   c = 7'd56;
      4'd12:   c = 7'd61;
      4'd13:   c = 7'd65;
      4'd14:   c = 7'd67;
      default: c = 7'd68;
    endcase
    return c;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  newest_q, newest_d;
  logic [3:0]        k_q, k_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] filtered_q, filtered_d;
  logic              out_valid_q, out_valid_d;
  logic              dropped_q, dropped_d;
  logic              accept;

  logic [DATA_W-1:0] line_q [TAPS];

  // Ages k and 30-k, both taken modulo 31 relative to the newest entry.
  logic [PTR_W:0]    new_sum, old_sum;
  logic [PTR_W-1:0]  idx_new, idx_old;
  logic [DATA_W-1:0] x_new, x_old;
  logic [PAIR_W-1:0] pair_sum;
  logic [PROD_W-1:0] product;
  logic [ACC_W-1:0]  scaled;

  always_comb begin
    new_sum = {1'b0, newest_q} + 6'd31 - {2'b00, k_q};
    idx_new = (new_sum >= 6'd31) ? PTR_W'(new_sum - 6'd31) : new_sum[PTR_W-1:0];
    old_sum = {1'b0, newest_q} + 6'd1 + {2'b00, k_q};
    idx_old = (old_sum >= 6'd31) ? PTR_W'(old_sum - 6'd31) : old_sum[PTR_W-1:0];
    x_new   = line_q[idx_new];
    x_old   = line_q[idx_old];
  end

  // The centre tap has no partner, so it contributes a single sample.
  assign pair_sum = (k_q == K_CENTRE) ? {1'b0, x_new} : ({1'b0, x_new} + {1'b0, x_old});
  assign product  = {{COEF_W{1'b0}}, pair_sum} * {{PAIR_W{1'b0}}, coef(k_q)};
  assign scaled   = acc_q >> SHIFT;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    newest_d    = newest_q;
    k_d         = k_q;
    acc_d       = acc_q;
    filtered_d  = filtered_q;
    out_valid_d = 1'b0;
    dropped_d   = sample_valid_i && (state_q != S_IDLE);
    accept      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sample_valid_i) begin
          accept   = 1'b1;
          newest_d = wr_ptr_q;
          wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
          acc_d    = '0;
          k_d      = '0;
          state_d  = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + {{(ACC_W-PROD_W){1'b0}}, product};
        k_d   = k_q + 1'b1;
        if (k_q == K_CENTRE) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        filtered_d  = (scaled > SAT_MAX) ? {DATA_W{1'b1}} : scaled[DATA_W-1:0];
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      newest_q    <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      filtered_q  <= '0;
      out_valid_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      newest_q    <= newest_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      filtered_q  <= filtered_d;
      out_valid_q <= out_valid_d;
      dropped_q   <= dropped_d;
    end
  end

  // The delay line must clear on reset, so it lives in flops rather than RAM.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < TAPS; i++) begin
        line_q[i] <= '0;
      end
    end else if (accept) begin
      line_q[wr_ptr_q] <= sample_i;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign out_valid_o = out_valid_q;
  assign filtered_o  = filtered_q;
  assign dropped_o   = dropped_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: direct-form golden model feeding a scoreboard,
// an impulse vector table, and hand-written drop/abort sequences.
module tb_fir_mac_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic [9:0] sample = '0;
  logic       busy, out_valid, dropped;
  logic [9:0] filtered;

  fir_mac_sequencer dut (
    .clk_i(clk), .reset_i(rst), .sample_valid_i(sample_valid), .sample_i(sample),
    .busy_o(busy), .out_valid_o(out_valid), .filtered_o(filtered), .dropped_o(dropped)
  );

  always #5 clk = ~clk;

  typedef struct { int value; int strobe_cyc; } exp_t;
  typedef struct { logic [9:0] smp; int exp; } vec_t;

  exp_t sb[$];
  vec_t imp_tbl[41];
  int   cf[16] = '{3, 4, 6, 8, 12, 17, 23, 29, 36, 43, 50, 56, 61, 65, 67, 68};
  int   imp_exp[31] = '{1, 2, 3, 4, 6, 8, 11, 14, 18, 21, 25, 28, 30, 32, 33, 34,
                        33, 32, 30, 28, 25, 21, 18, 14, 11, 8, 6, 4, 3, 2, 1};
  int   mline[31];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   drop_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_push(input int v);
    int acc;
    int r;
    for (int i = 30; i > 0; i--) mline[i] = mline[i-1];
    mline[0] = v;
    acc = 0;
    for (int i = 0; i < 31; i++) acc += cf[(i <= 15) ? i : 30 - i] * mline[i];
    r = acc >> 10;
    return (r > 1023) ? 1023 : r;
  endfunction

  // Scoreboard consumer: one line per produced output.
  always @(negedge clk) begin
    if (dropped) drop_cnt++;
    if (out_valid && !rst) begin
      n_out++;
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("out %0d: filtered=%0d expected=%0d latency=%0d", n_out, filtered, e.value, cyc - e.strobe_cyc);
        check("filtered", int'(filtered), e.value);
        check("latency", cyc - e.strobe_cyc, 18);
        check("busy_at_out_valid", int'(busy), 0);
      end
    end
  end

  // exp >= 0: fixed expectation; -1: golden model; -2: no result expected.
  task automatic send_now(input logic [9:0] v, input int exp);
    int y;
    sample_valid = 1'b1;
    sample = v;
    if (exp != -2) begin
      y = model_push(int'(v));
      sb.push_back('{(exp == -1) ? y : exp, cyc});
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic send(input logic [9:0] v, input int exp);
    @(negedge clk);
    send_now(v, exp);
    repeat (18) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 31; i++) mline[i] = 0;
  endtask

  task automatic run_impulse();
    for (int i = 0; i < 41; i++) send(imp_tbl[i].smp, imp_tbl[i].exp);
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int waited;
    for (int i = 0; i < 41; i++) begin
      imp_tbl[i].smp = (i == 0) ? 10'd512 : 10'd0;
      imp_tbl[i].exp = (i < 31) ? imp_exp[i] : 0;
    end
    for (int i = 0; i < 31; i++) mline[i] = 0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_dropped", int'(dropped), 0);
    check("reset_filtered", int'(filtered), 0);

    // Impulse response from the table.
    run_impulse();

    // Constant 512: ramp while filling, then exactly 514.
    do_reset();
    for (int i = 0; i < 35; i++) send(10'd512, (i >= 30) ? 514 : -1);
    drain();

    // Dropped strobe mid-computation, then a strobe on the out_valid cycle.
    d0 = drop_cnt;
    @(negedge clk);
    send_now(10'd100, -1);
    repeat (4) @(negedge clk);
    sample_valid = 1'b1;
    sample = 10'd900;
    @(negedge clk);
    sample_valid = 1'b0;
    check("dropped_pulse", int'(dropped), 1);
    check("busy_during_mac", int'(busy), 1);
    @(negedge clk);
    check("dropped_single_cycle", int'(dropped), 0);
    waited = 0;
    while (!out_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("out_valid_seen", int'(out_valid), 1);
    send_now(10'd700, -1);
    drain();
    check("drop_count", drop_cnt - d0, 1);

    // Saturation with a full line of 1023.
    do_reset();
    for (int i = 0; i < 32; i++) send(10'd1023, (i >= 30) ? 1023 : -1);
    drain();

    // Ramp across several pointer wraps.
    do_reset();
    for (int i = 0; i < 100; i++) send(10'(i), -1);
    drain();

    // Reset during MAC aborts the computation and clears the line.
    do_reset();
    @(negedge clk);
    send_now(10'd512, -2);
    repeat (7) @(negedge clk);
    check("busy_before_abort", int'(busy), 1);
    do_reset();
    check("abort_busy", int'(busy), 0);
    check("abort_filtered", int'(filtered), 0);
    repeat (25) @(negedge clk);
    check("abort_filtered_later", int'(filtered), 0);
    check("abort_busy_later", int'(busy), 0);
    run_impulse();

    check("total_drops", drop_cnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
